// File: rtl/test_status_pkg.sv
// ============================================================================
// Module : test_status_pkg
// Brief  : Shared verdict and state encodings for the run monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package test_status_pkg;

    typedef enum logic [2:0] {
        VERDICT_NONE    = 3'd0,
        VERDICT_PASS    = 3'd1,
        VERDICT_FAIL    = 3'd2,
        VERDICT_UNKNOWN = 3'd3,
        VERDICT_TIMEOUT = 3'd4
    } verdict_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/trace_ring_buffer.sv
// ============================================================================
// Module : trace_ring_buffer
// Brief  : Overwrite-oldest ring FIFO with show-ahead read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module trace_ring_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);
    assign w_pop   = pop_i && !w_empty;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // A push into a full ring drops the oldest entry, so the read side moves too.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (w_pop || (push_i && w_full)) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push_i && !w_full && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_i && w_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign data_o  = w_empty ? '0 : mem_q[rd_q];
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/test_status_monitor.sv
// ============================================================================
// Module : test_status_monitor
// Brief  : Run monitor: status-word snoop, cycle watchdog, PC trace, verdict.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module test_status_monitor
    import test_status_pkg::*;
#(
    parameter int                ADDR_W            = 32,
    parameter int                DATA_W            = 32,
    parameter int                NUM_CH            = 4,
    parameter logic [ADDR_W-1:0] STATUS_BASE       = 'h2000,
    parameter int                MAX_CYCLES        = 10000,
    parameter int                PROGRESS_INTERVAL = 100,
    parameter int                TRACE_DEPTH       = 16,
    parameter int                CYC_W             = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          halted,
    input  logic [ADDR_W-1:0]             pc,
    input  logic                          mem_wr_en,
    input  logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_wdata,
    input  logic                          trace_rd_en,
    output logic [ADDR_W-1:0]             trace_rd_data,
    output logic                          trace_empty,
    output logic [$clog2(TRACE_DEPTH):0]  trace_count,
    output logic                          progress_tick,
    output logic [CYC_W-1:0]              cycle_count,
    output logic [NUM_CH*DATA_W-1:0]      status_code,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    verdict
);

    localparam int INT_W = $clog2(PROGRESS_INTERVAL) + 1;

    state_t                   state_q,   state_d;
    verdict_t                 verdict_q, verdict_d;
    logic [CYC_W-1:0]         cycle_q,   cycle_d;
    logic [INT_W-1:0]         int_q,     int_d;
    logic [NUM_CH*DATA_W-1:0] status_q,  status_d;
    logic [NUM_CH-1:0]        valid_q,   valid_d;
    logic                     tick_q,    tick_d;
    logic                     w_clear;
    logic                     w_any_fail;
    logic                     w_all_pass;
    logic                     w_trace_full_unused;
    logic [NUM_CH-1:0]        w_hit;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_decode
        assign w_hit[i] = mem_wr_en && (mem_addr == STATUS_BASE + ADDR_W'(4 * i));
    end

    always_comb begin
        w_any_fail = 1'b0;
        w_all_pass = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (valid_q[i] && status_q[i*DATA_W +: DATA_W] == '0) begin
                w_any_fail = 1'b1;
            end
            if (!valid_q[i] || status_q[i*DATA_W +: DATA_W] != DATA_W'(1)) begin
                w_all_pass = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        cycle_d   = cycle_q;
        int_d     = int_q;
        status_d  = status_q;
        valid_d   = valid_q;
        tick_d    = 1'b0;
        w_clear   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    verdict_d = VERDICT_NONE;
                    cycle_d   = '0;
                    int_d     = '0;
                    status_d  = '0;
                    valid_d   = '0;
                    w_clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (int_q == INT_W'(PROGRESS_INTERVAL - 1)) begin
                    int_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    int_d = int_q + 1'b1;
                end
                // Halt is checked first so it beats the watchdog on the same cycle.
                if (halted) begin
                    state_d = ST_EVAL;
                end else if (cycle_q == CYC_W'(MAX_CYCLES - 1)) begin
                    state_d   = ST_DONE;
                    verdict_d = VERDICT_TIMEOUT;
                    cycle_d   = CYC_W'(MAX_CYCLES);
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            ST_EVAL: begin
                state_d = ST_DONE;
                if (w_any_fail) begin
                    verdict_d = VERDICT_FAIL;
                end else if (w_all_pass) begin
                    verdict_d = VERDICT_PASS;
                end else begin
                    verdict_d = VERDICT_UNKNOWN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_RUN || state_q == ST_EVAL) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_hit[i]) begin
                    status_d[i*DATA_W +: DATA_W] = mem_wdata;
                    valid_d[i]                   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            verdict_q <= VERDICT_NONE;
            cycle_q   <= '0;
            int_q     <= '0;
            status_q  <= '0;
            valid_q   <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
            cycle_q   <= cycle_d;
            int_q     <= int_d;
            status_q  <= status_d;
            valid_q   <= valid_d;
            tick_q    <= tick_d;
        end
    end

    trace_ring_buffer #(
        .WIDTH (ADDR_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (w_clear),
        .push_i  (tick_d),
        .pop_i   (trace_rd_en),
        .data_i  (pc),
        .data_o  (trace_rd_data),
        .empty_o (trace_empty),
        .full_o  (w_trace_full_unused),
        .count_o (trace_count)
    );

    assign cycle_count   = cycle_q;
    assign status_code   = status_q;
    assign verdict       = verdict_q;
    assign progress_tick = tick_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_EVAL);
    assign done          = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_test_status_monitor.sv
// ============================================================================
// Module : tb_test_status_monitor
// Brief  : Self-checking bench: vector table, trace corner cases, random runs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_test_status_monitor;

    localparam int          NUM_CH  = 2;
    localparam int          MAX_CYC = 60;
    localparam int          PI      = 2;
    localparam int          DEPTH   = 4;
    localparam int          LMAX    = 64;
    localparam logic [31:0] BASE    = 32'h2000;

    logic        clk = 1'b0;
    logic        rst_n, start, halted, mem_wr_en, trace_rd_en;
    logic [31:0] pc, mem_addr, mem_wdata, trace_rd_data, cycle_count;
    logic        trace_empty, progress_tick, busy, done;
    logic [2:0]  trace_count, verdict;
    logic [63:0] status_code;

    always #5 clk = ~clk;

    test_status_monitor #(
        .ADDR_W (32), .DATA_W (32), .NUM_CH (NUM_CH), .STATUS_BASE (BASE),
        .MAX_CYCLES (MAX_CYC), .PROGRESS_INTERVAL (PI), .TRACE_DEPTH (DEPTH), .CYC_W (32)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .halted (halted), .pc (pc),
        .mem_wr_en (mem_wr_en), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .trace_rd_en (trace_rd_en), .trace_rd_data (trace_rd_data),
        .trace_empty (trace_empty), .trace_count (trace_count),
        .progress_tick (progress_tick), .cycle_count (cycle_count),
        .status_code (status_code), .busy (busy), .done (done), .verdict (verdict)
    );

    typedef struct {
        int          halt_at;
        logic [31:0] a0; logic [31:0] d0; int c0;
        logic [31:0] a1; logic [31:0] d1; int c1;
        logic [31:0] a2; logic [31:0] d2; int c2;
        int          ev;
        int          ec;
    } vec_t;

    vec_t        tbl[10];
    int          n_pass  = 0;
    int          n_total = 0;
    logic        sch_en[LMAX];
    logic        sch_pop[LMAX];
    logic        sch_start[LMAX];
    logic [31:0] sch_a[LMAX];
    logic [31:0] sch_d[LMAX];
    int          q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < LMAX; i++) begin
            sch_en[i] = 1'b0; sch_pop[i] = 1'b0; sch_start[i] = 1'b0;
            sch_a[i] = '0; sch_d[i] = '0;
        end
    endtask

    task automatic put_wr(input int c, input logic [31:0] a, input logic [31:0] d);
        if (c > 0) begin
            sch_en[c] = 1'b1; sch_a[c] = a; sch_d[c] = d;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_verdict"}, verdict, 0);
        chk({tag, "_cycle"}, cycle_count, 0);
        chk({tag, "_status"}, status_code, 0);
        chk({tag, "_tcount"}, trace_count, 0);
        chk({tag, "_tempty"}, trace_empty, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tick"}, progress_tick, 0);
        chk({tag, "_tdata"}, trace_rd_data, 0);
    endtask

    // One complete run; expectations come from a run-level model of the rules.
    task automatic run_case(input string tag, input int halt_at, input bit drain,
                            input int tbl_v, input int tbl_cyc);
        int          L, ticks, ch, mv, dump;
        bit          is_to, any_fail, all_pass;
        logic [31:0] vals[NUM_CH];
        logic        vld[NUM_CH];
        logic [31:0] a;
        logic [63:0] exp_st;

        is_to = (halt_at < 0);
        L     = is_to ? MAX_CYC : halt_at + 1;
        ticks = 0;
        q.delete();

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        chk({tag, "_cycle_start"}, cycle_count, 0);
        chk({tag, "_status_start"}, status_code, 0);
        chk({tag, "_tcount_start"}, trace_count, 0);
        chk({tag, "_verdict_start"}, verdict, 0);

        for (int r = 1; r <= L; r++) begin
            pc          = 32'(r);
            mem_wr_en   = sch_en[r];
            mem_addr    = sch_a[r];
            mem_wdata   = sch_d[r];
            trace_rd_en = sch_pop[r];
            start       = sch_start[r];
            halted      = !is_to && (r == L);
            @(posedge clk); #1;
            if (progress_tick) ticks++;
            if (sch_pop[r] && q.size() > 0) dump = q.pop_front();
            if (r % PI == 0) begin
                if (q.size() == DEPTH) dump = q.pop_front();
                q.push_back(r);
            end
            chk({tag, "_tcount_run"}, trace_count, q.size());
            chk({tag, "_tdata_run"}, trace_rd_data, (q.size() > 0) ? q[0] : 0);
            if (r < L) chk({tag, "_cycle_run"}, cycle_count, r);
        end
        mem_wr_en = 1'b0; trace_rd_en = 1'b0; start = 1'b0; halted = 1'b0;

        if (!is_to) begin
            chk({tag, "_done_in_eval"}, done, 0);
            @(posedge clk); #1;
            if (progress_tick) ticks++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_ticks"}, ticks, L / PI);

        for (int c = 0; c < NUM_CH; c++) begin
            vals[c] = '0; vld[c] = 1'b0;
        end
        for (int r = 1; r <= L; r++) begin
            a = sch_a[r];
            if (sch_en[r] && a >= BASE && a < BASE + 32'(4 * NUM_CH) && a[1:0] == 2'b00) begin
                ch       = int'((a - BASE) >> 2);
                vals[ch] = sch_d[r];
                vld[ch]  = 1'b1;
            end
        end
        exp_st = '0;
        for (int c = 0; c < NUM_CH; c++) exp_st[c*32 +: 32] = vals[c];
        if (is_to) mv = 4;
        else begin
            any_fail = 1'b0; all_pass = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (vld[c] && vals[c] == 0) any_fail = 1'b1;
                if (!(vld[c] && vals[c] == 1)) all_pass = 1'b0;
            end
            mv = any_fail ? 2 : (all_pass ? 1 : 3);
        end
        chk({tag, "_verdict_model"}, verdict, mv);
        chk({tag, "_cycle_end"}, cycle_count, is_to ? MAX_CYC : halt_at);
        chk({tag, "_status_end"}, status_code, exp_st);
        if (tbl_v >= 0) begin
            chk({tag, "_verdict_table"}, verdict, tbl_v);
            chk({tag, "_cycle_table"}, cycle_count, tbl_cyc);
        end

        if (drain) begin
            while (q.size() > 0) begin
                chk({tag, "_pop_data"}, trace_rd_data, q[0]);
                trace_rd_en = 1'b1;
                @(posedge clk); #1;
                trace_rd_en = 1'b0;
                dump = q.pop_front();
            end
            chk({tag, "_drain_empty"}, trace_empty, 1);
            chk({tag, "_drain_count"}, trace_count, 0);
        end
    endtask

    initial begin
        int ha, c, L;
        logic [31:0] ra, rd;

        tbl[0] = '{50, 32'h2000, 1, 3, 32'h2004, 1, 5, 0, 0, 0, 1, 50};
        tbl[1] = '{20, 32'h2000, 1, 2, 32'h2004, 0, 21, 0, 0, 0, 2, 20};
        tbl[2] = '{10, 32'h2000, 1, 1, 0, 0, 0, 0, 0, 0, 3, 10};
        tbl[3] = '{10, 32'h2000, 1, 1, 32'h2004, 7, 2, 0, 0, 0, 3, 10};
        tbl[4] = '{-1, 32'h2000, 1, 1, 32'h2004, 1, 2, 0, 0, 0, 4, 60};
        tbl[5] = '{59, 32'h2000, 1, 1, 32'h2004, 1, 2, 0, 0, 0, 1, 59};
        tbl[6] = '{8, 32'h2004, 0, 2, 32'h2000, 1, 3, 32'h2004, 1, 4, 1, 8};
        tbl[7] = '{6, 32'h2002, 0, 1, 32'h2008, 0, 2, 32'h2000, 1, 3, 3, 6};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
        tbl[9] = '{11, 32'h2000, 0, 5, 32'h2004, 1, 6, 0, 0, 0, 2, 11};

        rst_n = 1'b0; start = 1'b0; halted = 1'b0; pc = '0;
        mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0; trace_rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        trace_rd_en = 1'b1;
        @(posedge clk); #1;
        trace_rd_en = 1'b0;
        chk("idle_pop_empty", trace_empty, 1);
        chk("idle_pop_count", trace_count, 0);

        for (int i = 0; i < 10; i++) begin
            clear_sched();
            put_wr(tbl[i].c0, tbl[i].a0, tbl[i].d0);
            put_wr(tbl[i].c1, tbl[i].a1, tbl[i].d1);
            put_wr(tbl[i].c2, tbl[i].a2, tbl[i].d2);
            run_case($sformatf("vec%0d", i), tbl[i].halt_at, (i % 3) != 1, tbl[i].ev, tbl[i].ec);
        end

        // Pops at cycles 14..16: push+pop while full, lone pop, push+pop below full.
        clear_sched();
        sch_pop[14] = 1'b1; sch_pop[15] = 1'b1; sch_pop[16] = 1'b1;
        run_case("trace_full", 16, 1'b0, 3, 16);
        chk("trace_full_count", trace_count, 3);
        chk("trace_full_head", trace_rd_data, 12);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int r = 1; r <= 9; r++) begin
            pc = 32'(r); mem_wr_en = (r == 2); mem_addr = BASE; mem_wdata = 32'd1;
            @(posedge clk); #1;
        end
        mem_wr_en = 1'b0;
        chk("pre_rst_count", trace_count, 4);
        chk("pre_rst_status", status_code, 64'd1);
        rst_n = 1'b0; pc = 32'd10;
        @(posedge clk); #1;
        chk_reset_outputs("midrun_rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", busy, 0);

        for (int n = 0; n < 12; n++) begin
            clear_sched();
            ha = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, MAX_CYC - 1));
            L  = (ha < 0) ? MAX_CYC : ha + 1;
            for (int k = 0; k < 4; k++) begin
                c = int'($urandom_range(1, L));
                case ($urandom_range(0, 5))
                    0: ra = 32'h2000;
                    1: ra = 32'h2004;
                    2: ra = 32'h2008;
                    3: ra = 32'h2002;
                    4: ra = 32'h1FFC;
                    default: ra = $urandom;
                endcase
                case ($urandom_range(0, 4))
                    0: rd = 32'd0;
                    1, 2: rd = 32'd1;
                    3: rd = 32'd7;
                    default: rd = $urandom;
                endcase
                put_wr(c, ra, rd);
            end
            for (int r = 1; r <= L; r++) begin
                sch_pop[r]   = ($urandom_range(0, 3) == 0);
                sch_start[r] = ($urandom_range(0, 15) == 0);
            end
            run_case($sformatf("rnd%0d", n), ha, (n % 2) == 0, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
